// File: rtl/i2c_controller.sv
// i2c_controller: single-byte I2C bus initiator (START, addr+R/W, ACK, data, ACK/NACK, STOP)
// Ports: clk, rst (async, active high); cmd_valid/cmd_ready handshake with cmd_addr, cmd_rw, cmd_wdata;
//        busy, done, nack, rd_data, rd_valid status; scl_in/sda_in sampled pins;
//        scl_oe/sda_oe open-drain enables (1 = pull the line low).
module i2c_controller #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       scl_in,
    output logic       scl_oe,
    input  logic       sda_in,
    output logic       sda_oe
);
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NACK, STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    q;
    logic [2:0]    idx;
    logic [7:0]    shift, rx, wdata;
    logic          rw;
    logic          wrap, hold;

    assign wrap      = cnt == CW'(CLK_DIV - 1);
    // a subordinate holding SCL low freezes the quarter counter at the start of q2
    assign hold      = q == 2'd2 && cnt == '0 && !scl_in;
    assign cmd_ready = state == IDLE && !rst;

    // {scl_oe, sda_oe} for quarter p of a segment in state s; b is the bit being sent
    function automatic logic [1:0] lines(input state_t s, input logic [1:0] p, input logic b);
        lines = s == IDLE                ? 2'b00 :
                s == START               ? {p == 2'd3, p[1]} :
                s == STOP                ? {~p[1], p != 2'd3} :
                s == ADDR || s == WDATA  ? {~p[1], ~b} :
                                           {~p[1], 1'b0};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            q        <= '0;
            idx      <= '0;
            shift    <= '0;
            rx       <= '0;
            wdata    <= '0;
            rw       <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            if (state == IDLE) begin
                if (cmd_valid) begin
                    state <= START;
                    cnt   <= '0;
                    q     <= '0;
                    shift <= {cmd_addr, cmd_rw};
                    rw    <= cmd_rw;
                    wdata <= cmd_wdata;
                    nack  <= 1'b0;
                    busy  <= 1'b1;
                end
            end else begin
                cnt <= wrap ? '0 : cnt + CW'(!hold);
                if (wrap) begin
                    q <= q + 2'd1;
                    if (q != 2'd3) begin
                        {scl_oe, sda_oe} <= lines(state, q + 2'd1, shift[7]);
                    end else begin
                        case (state)
                            START: begin
                                state            <= ADDR;
                                idx              <= '0;
                                {scl_oe, sda_oe} <= lines(ADDR, 2'd0, shift[7]);
                            end
                            ADDR, WDATA, RDATA: begin
                                // rx shifts in every byte; only the last eight samples of RDATA survive
                                shift <= {shift[6:0], 1'b0};
                                rx    <= {rx[6:0], sda_in};
                                idx   <= idx + 3'd1;
                                if (idx == 3'd7) begin
                                    state            <= state == ADDR ? ADDR_ACK : state == WDATA ? WDATA_ACK : RDATA_NACK;
                                    {scl_oe, sda_oe} <= 2'b10;
                                end else begin
                                    {scl_oe, sda_oe} <= lines(state, 2'd0, shift[6]);
                                end
                            end
                            ADDR_ACK: begin
                                state            <= sda_in ? STOP : rw ? RDATA : WDATA;
                                nack             <= sda_in;
                                shift            <= wdata;
                                {scl_oe, sda_oe} <= {1'b1, sda_in || (!rw && !wdata[7])};
                            end
                            WDATA_ACK: begin
                                state            <= STOP;
                                nack             <= sda_in;
                                {scl_oe, sda_oe} <= 2'b11;
                            end
                            RDATA_NACK: begin
                                state            <= STOP;
                                {scl_oe, sda_oe} <= 2'b11;
                            end
                            default: begin
                                state            <= IDLE;
                                busy             <= 1'b0;
                                done             <= 1'b1;
                                {scl_oe, sda_oe} <= 2'b00;
                                if (rw && !nack) begin
                                    rd_data  <= rx;
                                    rd_valid <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_controller.sv
// tb_i2c_controller: transactions checked against a bus-level subordinate and reference model
module tb_i2c_controller;
    localparam int D    = 4;
    localparam int HOLD = 13;

    logic       clk = 1'b0, rst = 1'b0;
    logic       cmd_valid = 1'b0, cmd_rw = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       cmd_ready, busy, done, nack, rd_valid, scl_oe, sda_oe;
    logic [7:0] rd_data;
    logic       scl, sda;

    int   checks = 0, passes = 0;
    int   txn_id = 0, seen_m = 0, seen_s = 0;
    logic s_rw = 1'b0, s_aa = 1'b0, s_ad = 1'b0;
    logic [7:0] s_rb = '0, last_rd = '0;
    int   stretch_at = 0, falls = 0;
    logic stretch = 1'b0, pull = 1'b0;
    int   slot = 0, hi_edges = 0, hold_edges = 0;
    logic bits[$];
    logic ps = 1'b1, pd = 1'b1, pso = 1'b0, pdo = 1'b0, pst = 1'b0;

    assign scl = !(scl_oe || stretch);
    assign sda = !(sda_oe || pull);

    i2c_controller #(.CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
        .busy(busy), .done(done), .nack(nack), .rd_data(rd_data), .rd_valid(rd_valid),
        .scl_in(scl), .scl_oe(scl_oe), .sda_in(sda), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // subordinate pull-down wanted during SCL-high slot k (1-based)
    function automatic logic want(input int k);
        return k == 9 ? s_aa :
               (s_aa && s_rw && k >= 10 && k <= 17) ? !s_rb[17 - k] :
               (s_aa && !s_rw && k == 18) ? s_ad : 1'b0;
    endfunction

    // bus monitor and subordinate: records SDA at each SCL rise, drives SDA after each SCL fall
    initial forever begin
        @(negedge clk);
        if (seen_m != txn_id) begin
            seen_m = txn_id;
            slot = 0;
            bits.delete();
            hi_edges = 0;
            hold_edges = 0;
        end
        if (scl && !ps) begin
            slot++;
            bits.push_back(sda);
        end
        if (!scl && ps) pull = want(slot + 1);
        if (scl && ps && sda != pd) hi_edges++;
        if (stretch && pst && (scl_oe != pso || sda_oe != pdo)) hold_edges++;
        ps = scl; pd = sda; pso = scl_oe; pdo = sda_oe; pst = stretch;
    end

    // clock stretcher: holds SCL low for HOLD cycles after the chosen controller release
    initial forever begin
        @(negedge scl_oe);
        if (seen_s != txn_id) begin
            seen_s = txn_id;
            falls = 0;
        end
        falls++;
        if (stretch_at != 0 && falls == stretch_at) begin
            stretch = 1'b1;
            repeat (HOLD) @(posedge clk);
            #1 stretch = 1'b0;
        end
    end

    task automatic txn(input logic [6:0] a, input logic rw, input logic [7:0] wd, input logic aa, input logic ad,
                       input logic [7:0] rb, input int st, input bit extra);
        int n, dones, rv_early, lat;
        logic [7:0] ab, db;
        logic e[$];
        s_rw = rw; s_aa = aa; s_ad = ad; s_rb = rb; stretch_at = st;
        txn_id++;
        @(negedge clk);
        check("ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_addr = a; cmd_rw = rw; cmd_wdata = wd;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_wdata = ~wd;
        check("busy", busy, 1'b1);
        check("nack_clr", nack, 1'b0);
        n = 0;
        rv_early = 0;
        while (!done && n < 3000) begin
            if (extra && n == 50) begin
                cmd_valid = 1'b1; cmd_addr = ~a; cmd_rw = ~rw;
            end
            if (n == 53) cmd_valid = 1'b0;
            if (rd_valid) rv_early++;
            @(posedge clk);
            #1 n++;
        end
        lat = (aa ? 80 : 44) * D + (st != 0 ? HOLD : 0);
        check("latency", n, lat);
        check("busy_end", busy, 1'b0);
        check("nack", nack, !aa || (!rw && !ad));
        check("rd_valid", rd_valid, rw && aa);
        if (rw && aa) last_rd = rb;
        check("rd_data", rd_data, last_rd);
        check("rv_early", rv_early, 0);
        @(posedge clk);
        #1;
        check("done_pulse", {done, rd_valid}, 2'b00);
        check("nack_hold", nack, !aa || (!rw && !ad));
        ab = {a, rw};
        for (int i = 7; i >= 0; i--) e.push_back(ab[i]);
        e.push_back(!aa);
        if (aa) begin
            db = rw ? rb : wd;
            for (int i = 7; i >= 0; i--) e.push_back(db[i]);
            e.push_back(rw || !ad);
        end
        e.push_back(1'b0);
        check("slots", bits.size(), e.size());
        for (int i = 0; i < e.size() && i < bits.size(); i++) check($sformatf("sda_slot%0d", i), bits[i], e[i]);
        check("sda_hi_edges", hi_edges, 2);
        if (st != 0) check("hold_edges", hold_edges, 0);
        if (extra) begin
            dones = 0;
            repeat (200) begin
                @(posedge clk);
                #1 if (done) dones++;
            end
            check("extra_done", dones, 0);
            check("idle_after", busy, 1'b0);
        end
    endtask

    task automatic rst_mid();
        int n;
        s_rw = 1'b0; s_aa = 1'b1; s_ad = 1'b1; s_rb = '0; stretch_at = 0;
        txn_id++;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 7'($urandom); cmd_rw = 1'b0; cmd_wdata = 8'($urandom) & 8'hFB;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (n = 0; n < 3000 && slot < 14; n++) @(negedge clk);
        for (; n < 3000 && !scl_oe; n++) @(negedge clk);
        check("pre_rst_lines", {scl_oe, sda_oe, busy}, 3'b111);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_lines", {scl_oe, sda_oe, busy, done}, 4'b0000);
        check("rst_rd", {rd_data, rd_valid, nack}, 10'h000);
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_state", {scl_oe, sda_oe, busy, done, nack, rd_valid}, 6'b000000);
        check("rst_rdata", rd_data, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_out", cmd_ready, 1'b1);
        txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 0, 1'b0);
        txn(7'h12, 1'b0, 8'h77, 1'b0, 1'b1, 8'h00, 0, 1'b0);
        txn(7'h50, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3C, 0, 1'b0);
        txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 13, 1'b0);
        txn(7'h2B, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 0, 1'b0);
        txn(7'h12, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFF, 0, 1'b0);
        rst_mid();
        txn(7'h50, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00, 0, 1'b1);
        for (int i = 0; i < 8; i++)
            txn(7'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, 8'($urandom), 0, 1'b0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
